// File: rtl/wb_ic_pkg.sv
// Shared types and default SoC address map for the Wishbone interconnect.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StResp
  } ic_state_t;

  typedef enum logic [1:0] {
    CauseNone     = 2'b00,
    CauseUnmapped = 2'b01,
    CauseTimeout  = 2'b10,
    CauseSlave    = 2'b11
  } err_cause_t;

  localparam logic [31:0] SramBase  = 32'h8000_0000;
  localparam logic [31:0] SramMask  = 32'hF000_0000;
  localparam logic [31:0] ClintBase = 32'h0200_0000;
  localparam logic [31:0] ClintMask = 32'hFFFF_0000;
  localparam logic [31:0] LedBase   = 32'h0201_0000;
  localparam logic [31:0] LedMask   = 32'hFFFF_0000;

  // Slave 0 lands in the least significant slice of the packed vector.
  function automatic logic [95:0] pack_map3(input logic [31:0] s0, input logic [31:0] s1,
                                            input logic [31:0] s2);
    return {s2, s1, s0};
  endfunction

  localparam logic [95:0] SocSlvBase = pack_map3(SramBase, ClintBase, LedBase);
  localparam logic [95:0] SocSlvMask = pack_map3(SramMask, ClintMask, LedMask);

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: base/mask match per slave, lowest index wins.
module wb_addr_decode #(
  parameter int unsigned                        NumSlaves = 3,
  parameter int unsigned                        AddrWidth = 32,
  parameter int unsigned                        IdxWidth  = 2,
  parameter logic [NumSlaves*AddrWidth-1:0]     SlvBase   = '0,
  parameter logic [NumSlaves*AddrWidth-1:0]     SlvMask   = '0
) (
  input  logic [AddrWidth-1:0] adr_i,
  output logic                 hit_o,
  output logic [IdxWidth-1:0]  idx_o
);

  logic [NumSlaves-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < int'(NumSlaves); i++) begin
      match[i] = (adr_i & SlvMask[i*AddrWidth +: AddrWidth]) ==
                 (SlvBase[i*AddrWidth +: AddrWidth] & SlvMask[i*AddrWidth +: AddrWidth]);
    end
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_o = |match;
    idx_o = '0;
    for (int i = int'(NumSlaves) - 1; i >= 0; i--) begin
      if (match[i]) idx_o = IdxWidth'(i);
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone interconnect with registered request path,
// unmapped/timeout/slave error responses and sticky fault capture.
module wb_interconnect
  import wb_ic_pkg::*;
#(
  parameter int unsigned                         NUM_SLAVES     = 3,
  parameter int unsigned                         ADDR_WIDTH     = 32,
  parameter int unsigned                         DATA_WIDTH     = 32,
  parameter int unsigned                         TIMEOUT_CYCLES = 255,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLV_BASE       = SocSlvBase,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLV_MASK       = SocSlvMask
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  input  logic                             m_we_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic                             m_stall_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i,
  input  logic                             err_clr_i,
  output logic                             err_valid_o,
  output logic [1:0]                       err_cause_o,
  output logic [ADDR_WIDTH-1:0]            err_addr_o
);

  localparam int unsigned SelWidth = DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  ic_state_t             state_q, state_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  ack_q, ack_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  we_q;
  logic [SelWidth-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic                  fvalid_q;
  err_cause_t            fcause_q;
  logic [ADDR_WIDTH-1:0] fadr_q;

  logic                  dec_hit;
  logic [IdxWidth-1:0]   dec_idx;
  logic                  latch;
  logic                  fault;
  err_cause_t            fault_cause;
  logic [ADDR_WIDTH-1:0] fault_adr;
  logic                  sel_ack, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdat;

  wb_addr_decode #(
    .NumSlaves (NUM_SLAVES),
    .AddrWidth (ADDR_WIDTH),
    .IdxWidth  (IdxWidth),
    .SlvBase   (SLV_BASE),
    .SlvMask   (SLV_MASK)
  ) u_decode (
    .adr_i (m_adr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  // Only the latched slave is observed; everyone else's ack/err is ignored.
  always_comb begin
    sel_ack  = 1'b0;
    sel_err  = 1'b0;
    sel_rdat = '0;
    s_cyc_o  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == IdxWidth'(i)) begin
        sel_ack    = s_ack_i[i];
        sel_err    = s_err_i[i];
        sel_rdat   = s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_cyc_o[i] = (state_q == StActive);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    latch       = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdat_d      = '0;
    fault       = 1'b0;
    fault_cause = CauseNone;
    unique case (state_q)
      StIdle: begin
        if (m_cyc_i && m_stb_i) begin
          latch = 1'b1;
          if (dec_hit) begin
            state_d = StActive;
            idx_d   = dec_idx;
            cnt_d   = '0;
          end else begin
            state_d     = StResp;
            err_d       = 1'b1;
            fault       = 1'b1;
            fault_cause = CauseUnmapped;
          end
        end
      end
      StActive: begin
        // Master abort beats any slave response arriving in the same cycle.
        if (!m_cyc_i) begin
          state_d = StIdle;
        end else if (sel_err) begin
          state_d     = StResp;
          err_d       = 1'b1;
          fault       = 1'b1;
          fault_cause = CauseSlave;
        end else if (sel_ack) begin
          state_d = StResp;
          ack_d   = 1'b1;
          rdat_d  = sel_rdat;
        end else if (cnt_q == CntLast) begin
          state_d     = StResp;
          err_d       = 1'b1;
          fault       = 1'b1;
          fault_cause = CauseTimeout;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign fault_adr = (state_q == StIdle) ? m_adr_i : adr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      if (latch) begin
        we_q   <= m_we_i;
        sel_q  <= m_sel_i;
        adr_q  <= m_adr_i;
        wdat_q <= m_dat_i;
      end
    end
  end

  // A fault raised together with a clear wins, so nothing is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fvalid_q <= 1'b0;
      fcause_q <= CauseNone;
      fadr_q   <= '0;
    end else if (fault && (!fvalid_q || err_clr_i)) begin
      fvalid_q <= 1'b1;
      fcause_q <= fault_cause;
      fadr_q   <= fault_adr;
    end else if (err_clr_i) begin
      fvalid_q <= 1'b0;
      fcause_q <= CauseNone;
      fadr_q   <= '0;
    end
  end

  assign s_stb_o     = s_cyc_o;
  assign s_we_o      = we_q;
  assign s_sel_o     = sel_q;
  assign s_adr_o     = adr_q;
  assign s_dat_o     = wdat_q;
  assign m_ack_o     = ack_q & m_cyc_i;
  assign m_err_o     = err_q & m_cyc_i;
  assign m_dat_o     = rdat_q;
  assign m_stall_o   = (state_q != StIdle);
  assign err_valid_o = fvalid_q;
  assign err_cause_o = fcause_q;
  assign err_addr_o  = fadr_q;

endmodule

// File: tb/tb_wb_interconnect.sv
// Bench for wb_interconnect: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  // slave0 sram, slave1 alias overlapping sram (0x8..0xB), slave2 led, slave3 clint
  localparam logic [NS*AW-1:0] BASE = {32'h0200_0000, 32'h0201_0000, 32'h8000_0000, 32'h8000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hC000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst_n;
  logic m_cyc, m_stb, m_we;
  logic [3:0] m_sel;
  logic [31:0] m_adr, m_dat;
  logic [31:0] m_dat_o;
  logic m_ack_o, m_err_o, m_stall_o;
  logic [NS-1:0] s_cyc_o, s_stb_o;
  logic s_we_o;
  logic [3:0] s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [NS*DW-1:0] s_dat;
  logic [NS-1:0] s_ack, s_err;
  logic err_clr;
  logic err_valid_o;
  logic [1:0] err_cause_o;
  logic [31:0] err_addr_o;

  int checks = 0;
  int errors = 0;

  // responder controls
  int   rsp_lat = 0;
  bit   rsp_never = 0, rsp_err = 0, rsp_both = 0, rsp_fix = 0;
  int   spur = 0;

  wb_interconnect #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .SLV_BASE       (BASE),
    .SLV_MASK       (MASK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_cyc_i     (m_cyc),
    .m_stb_i     (m_stb),
    .m_we_i      (m_we),
    .m_sel_i     (m_sel),
    .m_adr_i     (m_adr),
    .m_dat_i     (m_dat),
    .m_dat_o     (m_dat_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .m_stall_o   (m_stall_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_sel_o     (s_sel_o),
    .s_adr_o     (s_adr_o),
    .s_dat_o     (s_dat_o),
    .s_dat_i     (s_dat),
    .s_ack_i     (s_ack),
    .s_err_i     (s_err),
    .err_clr_i   (err_clr),
    .err_valid_o (err_valid_o),
    .err_cause_o (err_cause_o),
    .err_addr_o  (err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          mdl_busy;
  int          mdl_idx, mdl_age, mdl_resp;  // resp: 0 none, 1 ack, 2 err
  logic [31:0] mdl_rdata, mdl_adr, mdl_wdat;
  logic [3:0]  mdl_sel;
  logic        mdl_we;
  bit          f_valid;
  logic [1:0]  f_cause;
  logic [31:0] f_addr;

  function automatic int decode(input logic [31:0] a);
    logic [NS*AW-1:0] b, m;
    b = BASE;
    m = MASK;
    for (int i = 0; i < NS; i++)
      if ((a & m[i*AW +: AW]) == (b[i*AW +: AW] & m[i*AW +: AW])) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mdl_busy = 0; mdl_idx = 0; mdl_age = 0; mdl_resp = 0; mdl_rdata = 0;
    f_valid = 0; f_cause = 0; f_addr = 0;
  endtask

  task automatic model_step();
    bit n_busy = mdl_busy;
    int n_idx = mdl_idx, n_age = mdl_age, n_resp = 0, d;
    logic [31:0] n_rdata = 0, fa = 0;
    bit fault = 0;
    logic [1:0] fc = 0;
    logic [NS*DW-1:0] sd = s_dat;
    if (mdl_resp != 0) begin
      n_busy = 0;
    end else if (!mdl_busy) begin
      if (m_cyc && m_stb) begin
        mdl_we = m_we; mdl_sel = m_sel; mdl_adr = m_adr; mdl_wdat = m_dat;
        d = decode(m_adr);
        if (d >= 0) begin
          n_busy = 1; n_idx = d; n_age = 0;
        end else begin
          n_resp = 2; fault = 1; fc = 2'b01; fa = m_adr;
        end
      end
    end else if (!m_cyc) begin
      n_busy = 0;
    end else if (s_err[mdl_idx]) begin
      n_busy = 0; n_resp = 2; fault = 1; fc = 2'b11; fa = mdl_adr;
    end else if (s_ack[mdl_idx]) begin
      n_busy = 0; n_resp = 1; n_rdata = sd[mdl_idx*DW +: DW];
    end else if (mdl_age == TO - 1) begin
      n_busy = 0; n_resp = 2; fault = 1; fc = 2'b10; fa = mdl_adr;
    end else begin
      n_age = mdl_age + 1;
    end
    if (fault && (!f_valid || err_clr)) begin
      f_valid = 1; f_cause = fc; f_addr = fa;
    end else if (err_clr) begin
      f_valid = 0; f_cause = 0; f_addr = 0;
    end
    mdl_busy = n_busy; mdl_idx = n_idx; mdl_age = n_age; mdl_resp = n_resp;
    mdl_rdata = n_rdata;
  endtask

  task automatic compare();
    logic [NS-1:0] exp_stb;
    exp_stb = mdl_busy ? NS'(1 << mdl_idx) : '0;
    chk("s_stb", 32'(s_stb_o), 32'(exp_stb));
    chk("s_cyc", 32'(s_cyc_o), 32'(exp_stb));
    chk("m_stall", 32'(m_stall_o), 32'(mdl_busy || mdl_resp != 0));
    chk("m_ack", 32'(m_ack_o), 32'(mdl_resp == 1 && m_cyc));
    chk("m_err", 32'(m_err_o), 32'(mdl_resp == 2 && m_cyc));
    chk("m_dat", m_dat_o, (mdl_resp == 1) ? mdl_rdata : 32'h0);
    chk("err_valid", 32'(err_valid_o), 32'(f_valid));
    chk("err_cause", 32'(err_cause_o), 32'(f_cause));
    chk("err_addr", err_addr_o, f_addr);
    if (exp_stb != 0) begin
      chk("s_we", 32'(s_we_o), 32'(mdl_we));
      chk("s_sel", 32'(s_sel_o), 32'(mdl_sel));
      chk("s_adr", s_adr_o, mdl_adr);
      chk("s_dat", s_dat_o, mdl_wdat);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare();
  end

  // ---------------- slave responder ----------------
  initial begin
    int age = 0;
    s_ack = '0; s_err = '0; s_dat = '0;
    forever begin
      @(negedge clk);
      s_dat = {$urandom, $urandom, $urandom, $urandom};
      if (rsp_fix) s_dat[31:0] = 32'hDEAD_BEEF;
      age = (s_stb_o != 0) ? age + 1 : 0;
      s_ack = '0;
      s_err = '0;
      if (age > 0 && age == rsp_lat + 1 && !rsp_never) begin
        if (rsp_err || rsp_both) s_err = s_stb_o;
        if (!rsp_err || rsp_both) s_ack = s_stb_o;
      end
      if (spur == 1) begin
        s_ack = s_ack | ~s_stb_o;
        s_err = s_err | ~s_stb_o;
      end else if (spur == 2) begin
        s_ack = s_ack | (NS'($urandom) & ~s_stb_o);
        s_err = s_err | (NS'($urandom) & ~s_stb_o);
      end
    end
  end

  // ---------------- master side ----------------
  task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, input int abort_at, input logic clr,
                     output logic got_ack, output logic got_err, output logic [31:0] rdat,
                     output int lat, output int stb_cycles, output logic [NS-1:0] first_stb);
    @(negedge clk);
    m_cyc = 1; m_stb = 1; m_adr = adr; m_we = we; m_dat = dat; m_sel = sel; err_clr = clr;
    got_ack = 0; got_err = 0; rdat = 0; stb_cycles = 0;
    @(negedge clk);
    m_stb = 0; err_clr = 0; lat = 1; first_stb = s_stb_o;
    while (lat < 40) begin
      if (s_stb_o != 0) stb_cycles++;
      if (m_ack_o || m_err_o) begin
        got_ack = m_ack_o; got_err = m_err_o; rdat = m_dat_o;
        break;
      end
      if (abort_at != 0 && lat == abort_at) break;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      checks++; errors++;
      $display("FAIL txn_bound: no response for adr %h within 40 cycles", adr);
    end
    m_cyc = 0;
  endtask

  task automatic clear_pulse();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return {4'h8, r[27:0]};
      1: return {2'b10, 2'($urandom_range(1, 3)), r[27:0]};
      2: return {16'h0201, r[15:0]};
      3: return {16'h0200, r[15:0]};
      default: return {4'h1, r[27:0]};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ga, ge;
    logic [31:0] rd;
    int lat, sc;
    logic [NS-1:0] fs;
    rst_n = 0; m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 0; m_adr = 0; m_dat = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_stb", 32'(s_stb_o), 0);
    chk("rst_stall", 32'(m_stall_o), 0);
    chk("rst_ack", 32'(m_ack_o), 0);
    chk("rst_valid", 32'(err_valid_o), 0);
    rst_n = 1;

    // sram read, slave acks one cycle after strobe
    rsp_lat = 1; rsp_fix = 1;
    txn(32'h8000_0010, 0, 0, 4'hF, 0, 0, ga, ge, rd, lat, sc, fs);
    chk("rd_first_stb", 32'(fs), 32'h1);
    chk("rd_lat", lat, 3);
    chk("rd_ack", 32'(ga), 1);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_valid", 32'(err_valid_o), 0);

    // led write, zero-wait slave
    rsp_lat = 0; rsp_fix = 0;
    txn(32'h0201_0000, 1, 32'h0000_00A5, 4'b0001, 0, 0, ga, ge, rd, lat, sc, fs);
    chk("wr_first_stb", 32'(fs), 32'h4);
    chk("wr_lat", lat, 2);
    chk("wr_ack", 32'(ga), 1);
    chk("wr_sdat", s_dat_o, 32'hA5);
    chk("wr_ssel", 32'(s_sel_o), 1);

    // unmapped accesses
    txn(32'h1000_0000, 0, 0, 4'hF, 0, 0, ga, ge, rd, lat, sc, fs);
    chk("um_lat", lat, 1);
    chk("um_err", 32'(ge), 1);
    chk("um_stb", sc, 0);
    chk("um_valid", 32'(err_valid_o), 1);
    chk("um_cause", 32'(err_cause_o), 1);
    chk("um_addr", err_addr_o, 32'h1000_0000);
    txn(32'h2000_0000, 0, 0, 4'hF, 0, 0, ga, ge, rd, lat, sc, fs);
    chk("um2_err", 32'(ge), 1);
    chk("um2_addr", err_addr_o, 32'h1000_0000);
    clear_pulse();
    chk("clr_valid", 32'(err_valid_o), 0);

    // clint timeout
    rsp_never = 1;
    txn(32'h0200_0004, 0, 0, 4'hF, 0, 0, ga, ge, rd, lat, sc, fs);
    chk("to_first_stb", 32'(fs), 32'h8);
    chk("to_stb_cycles", sc, 8);
    chk("to_lat", lat, 9);
    chk("to_err", 32'(ge), 1);
    chk("to_cause", 32'(err_cause_o), 2);
    chk("to_addr", err_addr_o, 32'h0200_0004);
    clear_pulse();
    chk("to_clr_valid", 32'(err_valid_o), 0);

    // overlapping map: slave 0 wins, slave 1 ack/err ignored
    rsp_never = 0; rsp_lat = 2; rsp_fix = 1; spur = 1;
    txn(32'h8000_0040, 0, 0, 4'hF, 0, 0, ga, ge, rd, lat, sc, fs);
    chk("ov_first_stb", 32'(fs), 32'h1);
    chk("ov_lat", lat, 4);
    chk("ov_ack", 32'(ga), 1);
    chk("ov_err", 32'(ge), 0);
    chk("ov_data", rd, 32'hDEAD_BEEF);
    spur = 0; rsp_fix = 0;

    // master abort two cycles into the slave access
    rsp_never = 1;
    txn(32'h0200_0008, 0, 0, 4'hF, 2, 0, ga, ge, rd, lat, sc, fs);
    @(negedge clk);
    chk("ab_stb", 32'(s_stb_o), 0);
    chk("ab_stall", 32'(m_stall_o), 0);
    chk("ab_resp", 32'({m_ack_o, m_err_o}), 0);
    chk("ab_valid", 32'(err_valid_o), 0);

    // async reset in the middle of a slave access, with a fault pending
    txn(32'h4000_0000, 0, 0, 4'hF, 0, 0, ga, ge, rd, lat, sc, fs);
    @(negedge clk);
    m_cyc = 1; m_stb = 1; m_adr = 32'h0200_0010;
    @(negedge clk);
    m_stb = 0;
    @(negedge clk);
    chk("rs_pre_stb", 32'(s_stb_o), 32'h8);
    rst_n = 0;
    #1;
    chk("rs_stb", 32'(s_stb_o), 0);
    chk("rs_stall", 32'(m_stall_o), 0);
    chk("rs_resp", 32'({m_ack_o, m_err_o}), 0);
    chk("rs_valid", 32'(err_valid_o), 0);
    m_cyc = 0;
    @(negedge clk);
    rst_n = 1;
    rsp_never = 0;

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      int ab;
      rsp_lat   = $urandom_range(0, 9);
      rsp_never = ($urandom_range(0, 9) == 0);
      rsp_err   = ($urandom_range(0, 5) == 0);
      rsp_both  = ($urandom_range(0, 7) == 0);
      spur      = $urandom_range(0, 2);
      ab        = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
      txn(rand_adr(), 1'($urandom), $urandom, 4'($urandom), ab, ($urandom_range(0, 3) == 0),
          ga, ge, rd, lat, sc, fs);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
